// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Shared constants and the event encoding used by the keypad debouncer.
//   Event byte layout: {isPress, 4'b0, keyIdx[2:0]}.
//   Optional build macro used by the top level: KEYPAD_RELEASE_EVENT_EN.
package keypad_pkg;

   localparam int KEY_COUNT     = 8;
   localparam int EVT_W         = 8;
   localparam int EVT_PRESS_BIT = 7;
   localparam int EVT_IDX_LSB   = 0;
   localparam int EVT_IDX_W     = 3;

   function automatic logic [EVT_W-1:0] evt_encode(input logic is_press,
                                                   input logic [EVT_IDX_W-1:0] idx);
      logic [EVT_W-1:0] evt;
      evt = '0;
      evt[EVT_PRESS_BIT] = is_press;
      evt[EVT_IDX_LSB +: EVT_IDX_W] = idx;
      return evt;
   endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// key_debounce_cell
//   One keypad line: 2-flop synchroniser, debounce counter and stable flop.
//   Ports:
//     clk        in   system clock
//     reset      in   synchronous active-low reset
//     raw        in   raw (asynchronous) key level
//     stable     out  debounced level (registered)
//     riseStrobe out  high in the cycle stable is about to go 0->1
//     fallStrobe out  high in the cycle stable is about to go 1->0
//   The strobes are decoded from registered state only, so the parent can
//   capture an event on the same edge that updates stable.
module key_debounce_cell #(
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int CNT_W           = 17
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable,
   output logic riseStrobe,
   output logic fallStrobe
);

   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_0;
   logic             sync_1;
   logic [CNT_W-1:0] cnt;
   logic             at_terminal;

   assign at_terminal = (sync_1 != stable) && (cnt == TERMINAL);
   assign riseStrobe  = at_terminal &  sync_1;
   assign fallStrobe  = at_terminal & ~sync_1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_0 <= 1'b0;
         sync_1 <= 1'b0;
         cnt    <= '0;
         stable <= 1'b0;
      end else begin
         sync_0 <= raw;
         sync_1 <= sync_0;
         // Any return to the accepted level restarts the qualification window.
         if (sync_1 == stable) begin
            cnt <= '0;
         end else if (cnt == TERMINAL) begin
            stable <= sync_1;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/keypad_debouncer.sv
// keypad_debouncer
//   Debounces the 8 raw keypad lines and queues key events in a small FIFO.
//   Ports:
//     clk           in   system clock
//     reset         in   synchronous active-low reset
//     keypadRaw     in   raw keypad lines, active-high
//     keypadStable  out  debounced level per key
//     evtValid      out  FIFO non-empty
//     evtData       out  head event {isPress, 4'b0, keyIdx}
//     evtPop        in   pop head entry (ignored when empty)
//     evtCount      out  occupied entries
//     overflow      out  sticky: an event was dropped on a full FIFO
//     clearOverflow in   clears overflow (a simultaneous new drop wins)
//   Build macro: KEYPAD_RELEASE_EVENT_EN adds release events (isPress=0);
//   presses always drain before releases.
module keypad_debouncer
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int FIFO_DEPTH      = 8,
   parameter int CNT_W           = 17
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [KEY_COUNT-1:0]          keypadRaw,
   output logic [KEY_COUNT-1:0]          keypadStable,
   output logic                          evtValid,
   output logic [EVT_W-1:0]              evtData,
   input  logic                          evtPop,
   output logic [$clog2(FIFO_DEPTH):0]   evtCount,
   output logic                          overflow,
   input  logic                          clearOverflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [KEY_COUNT-1:0] rise;
   logic [KEY_COUNT-1:0] fall;
   logic [KEY_COUNT-1:0] press_pend;
   logic [KEY_COUNT-1:0] press_clr;
   logic [KEY_COUNT-1:0] rel_clr;

   logic                 push;
   logic                 push_press;
   logic [EVT_IDX_W-1:0] push_idx;
   logic [EVT_W-1:0]     push_data;
   logic [KEY_COUNT-1:0] pick_mask;

   logic [EVT_W-1:0]     mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W:0]       count;
   logic                 full;
   logic                 pop;
   logic                 wr_en;
   logic                 drop;

   for (genvar i = 0; i < KEY_COUNT; i++) begin : g_cell
      key_debounce_cell #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_cell (
         .clk        (clk),
         .reset      (reset),
         .raw        (keypadRaw[i]),
         .stable     (keypadStable[i]),
         .riseStrobe (rise[i]),
         .fallStrobe (fall[i])
      );
   end

   function automatic logic [EVT_IDX_W-1:0] lowest_idx(input logic [KEY_COUNT-1:0] m);
      logic [EVT_IDX_W-1:0] r;
      r = '0;
      for (int i = KEY_COUNT - 1; i >= 0; i--) begin
         if (m[i]) r = EVT_IDX_W'(i);
      end
      return r;
   endfunction

`ifdef KEYPAD_RELEASE_EVENT_EN
   logic [KEY_COUNT-1:0] rel_pend;

   always_ff @(posedge clk) begin
      if (!reset) rel_pend <= '0;
      else        rel_pend <= (rel_pend & ~rel_clr) | fall;
   end
`else
   logic unused_fall;
   assign unused_fall = ^fall;
`endif

   always_comb begin
      push       = |press_pend;
      push_press = 1'b1;
      push_idx   = lowest_idx(press_pend);
`ifdef KEYPAD_RELEASE_EVENT_EN
      if (!(|press_pend) && (|rel_pend)) begin
         push       = 1'b1;
         push_press = 1'b0;
         push_idx   = lowest_idx(rel_pend);
      end
`endif
      push_data = evt_encode(push_press, push_idx);
      pick_mask = push ? (KEY_COUNT'(1) << push_idx) : '0;
      press_clr = push_press  ? pick_mask : '0;
      rel_clr   = !push_press ? pick_mask : '0;
   end

   // The pending bit is cleared whether or not the FIFO accepted the entry.
   always_ff @(posedge clk) begin
      if (!reset) press_pend <= '0;
      else        press_pend <= (press_pend & ~press_clr) | rise;
   end

   assign full  = (count == (PTR_W + 1)'(FIFO_DEPTH));
   assign pop   = evtPop && (count != '0);
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop)               overflow <= 1'b1;
         else if (clearOverflow) overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_data;
   end

   assign evtCount = count;
   assign evtValid = (count != '0);
   assign evtData  = evtValid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_keypad_debouncer.sv
module tb_keypad_debouncer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] keypadRaw;
   logic [7:0] keypadStable;
   logic       evtValid;
   logic [7:0] evtData;
   logic       evtPop;
   logic [2:0] evtCount;
   logic       overflow;
   logic       clearOverflow;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   keypad_debouncer #(
      .DEBOUNCE_CYCLES (16),
      .FIFO_DEPTH      (4),
      .CNT_W           (5)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .keypadRaw     (keypadRaw),
      .keypadStable  (keypadStable),
      .evtValid      (evtValid),
      .evtData       (evtData),
      .evtPop        (evtPop),
      .evtCount      (evtCount),
      .overflow      (overflow),
      .clearOverflow (clearOverflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic pop_n(input int n);
      evtPop = 1'b1;
      tick(n);
      evtPop = 1'b0;
   endtask

   task automatic do_reset();
      keypadRaw = 8'h00;
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(4);
   endtask

   // Scoreboard monitor: every accepted pop is compared against the oldest expectation.
   always @(negedge clk) begin
      logic [7:0] e;
      if (evtPop && evtValid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL evt_unexpected actual=%h expected=none", evtData);
         end else begin
            e = exp_q.pop_front();
            if (evtData !== e) begin
               errors++;
               $display("FAIL evt_data actual=%h expected=%h", evtData, e);
            end
         end
      end
   end

   initial begin
      reset = 1'b0;
      keypadRaw = 8'hFF;
      evtPop = 1'b0;
      clearOverflow = 1'b0;

      // 1: reset state, all-keys press latency, FIFO overflow
      tick(3);
      check("rst_stable", keypadStable, 8'h00);
      check("rst_valid", {7'd0, evtValid}, 8'h00);
      check("rst_data", evtData, 8'h00);
      check("rst_count", {5'd0, evtCount}, 8'h00);
      check("rst_ovf", {7'd0, overflow}, 8'h00);
      reset = 1'b1;
      tick(17);
      check("all_stable_17", keypadStable, 8'h00);
      tick(1);
      check("all_stable_18", keypadStable, 8'hFF);
      exp_q.push_back(8'h80);
      exp_q.push_back(8'h81);
      exp_q.push_back(8'h82);
      exp_q.push_back(8'h83);
      tick(8);
      check("all_ovf", {7'd0, overflow}, 8'h01);
      check("all_count", {5'd0, evtCount}, 8'h04);
      pop_n(4);
      check("all_drained_valid", {7'd0, evtValid}, 8'h00);
      check("all_drained_count", {5'd0, evtCount}, 8'h00);
      check("all_ovf_sticky", {7'd0, overflow}, 8'h01);
      clearOverflow = 1'b1;
      tick(1);
      clearOverflow = 1'b0;
      check("all_ovf_cleared", {7'd0, overflow}, 8'h00);

      // 2: short glitch on key 2
      do_reset();
      keypadRaw = 8'h04;
      tick(10);
      keypadRaw = 8'h00;
      tick(30);
      check("glitch_stable", keypadStable, 8'h00);
      check("glitch_valid", {7'd0, evtValid}, 8'h00);

      // 3: single press of key 5
      keypadRaw = 8'h20;
      tick(17);
      check("k5_stable_17", keypadStable, 8'h00);
      tick(1);
      check("k5_stable_18", keypadStable, 8'h20);
      check("k5_valid_18", {7'd0, evtValid}, 8'h00);
      tick(1);
      check("k5_valid_19", {7'd0, evtValid}, 8'h01);
      check("k5_data_19", evtData, 8'h85);
      exp_q.push_back(8'h85);
      pop_n(1);
      check("k5_popped_valid", {7'd0, evtValid}, 8'h00);

      // 4: keys 1,3,6 together, drained in index order
      keypadRaw = 8'h6A;
      exp_q.push_back(8'h81);
      exp_q.push_back(8'h83);
      exp_q.push_back(8'h86);
      tick(22);
      check("multi_count", {5'd0, evtCount}, 8'h03);
      pop_n(3);
      check("multi_drained", {7'd0, evtValid}, 8'h00);

      // 5: full FIFO, push with simultaneous pop, then push without pop
      do_reset();
      keypadRaw = 8'h1E;
      exp_q.push_back(8'h81);
      exp_q.push_back(8'h82);
      exp_q.push_back(8'h83);
      exp_q.push_back(8'h84);
      tick(24);
      check("full_count", {5'd0, evtCount}, 8'h04);
      keypadRaw = 8'h1F;
      tick(18);
      evtPop = 1'b1;
      tick(1);
      evtPop = 1'b0;
      exp_q.push_back(8'h80);
      check("pushpop_ovf", {7'd0, overflow}, 8'h00);
      check("pushpop_count", {5'd0, evtCount}, 8'h04);
      keypadRaw = 8'h3F;
      tick(20);
      check("drop_ovf", {7'd0, overflow}, 8'h01);
      check("drop_count", {5'd0, evtCount}, 8'h04);
      clearOverflow = 1'b1;
      tick(1);
      clearOverflow = 1'b0;
      check("clear_ovf", {7'd0, overflow}, 8'h00);
      pop_n(4);
      check("full_drained", {7'd0, evtValid}, 8'h00);

      // 6: press then release of key 4
      do_reset();
      keypadRaw = 8'h10;
      tick(25);
      keypadRaw = 8'h00;
      tick(25);
      exp_q.push_back(8'h84);
`ifdef KEYPAD_RELEASE_EVENT_EN
      exp_q.push_back(8'h04);
      check("rel_count", {5'd0, evtCount}, 8'h02);
      pop_n(2);
`else
      check("rel_count", {5'd0, evtCount}, 8'h01);
      pop_n(1);
`endif
      check("rel_drained", {7'd0, evtValid}, 8'h00);
      check("sb_leftover", 8'(exp_q.size()), 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
